// File: rtl/mc10_exp_cart.sv
`default_nettype none
// ============================================================================
// Module   : mc10_exp_cart
// Purpose  : Bank-switched cartridge responder for the MC-10 expansion
//            connector. Decodes the CPU address, asserts sel to override
//            on-board decoding, returns ROM data and latches a bank number
//            from address-only writes to $1000-$10FF. The ROM image arrives
//            over the download port; a completed load auto-boots the machine
//            with a reset pulse on the expansion connector.
// Ports    : clk_sys        - system clock (>= 4x E)
//            reset_n        - asynchronous active-low reset
//            exp_out[17:0]  - machine side: [17] R/W, [16:1] A15-A0, [0] E
//            exp_in[10:0]   - cart side: [10:3] D7-D0, [2] nmi, [1] reset,
//                             [0] sel
//            ioctl_*        - image download port
//            cart_loaded    - cartridge present and responding
//            bank           - current bank register
// Revision : 1.0 - initial release
// ============================================================================
module mc10_exp_cart #(
  parameter int BANK_W     = 3,
  parameter int RST_CYCLES = 1024
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [17:0]       exp_out,
  output logic [10:0]       exp_in,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [23:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              cart_loaded,
  output logic [BANK_W-1:0] bank
);

  localparam int ROM_AW    = BANK_W + 13;
  localparam int ROM_DEPTH = 1 << ROM_AW;
  localparam int CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_BOOT = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  // --------------------------------------------------------------------------
  // Bus field extraction
  // --------------------------------------------------------------------------
  logic        w_rw;
  logic [15:0] w_addr;
  logic        w_e;

  assign w_rw   = exp_out[17];
  assign w_addr = exp_out[16:1];
  assign w_e    = exp_out[0];

  // --------------------------------------------------------------------------
  // State machine: register / next-state / outputs
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic             wr_seen_q, wr_seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    // A new download pre-empts whatever the cartridge is doing.
    if (ioctl_download && (state_q != ST_LOAD)) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (!ioctl_download) begin
            // A strobe coinciding with the falling download still counts.
            state_d = (wr_seen_q || ioctl_wr) ? ST_BOOT : ST_IDLE;
          end
        end
        ST_BOOT: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  logic w_run;
  logic w_boot_rst;

  always_comb begin
    w_run       = (state_q == ST_RUN);
    w_boot_rst  = (state_q == ST_LOAD) || (state_q == ST_BOOT);
    cart_loaded = (state_q == ST_BOOT) || (state_q == ST_RUN);
  end

  // --------------------------------------------------------------------------
  // Download bookkeeping and boot-pulse counter
  // --------------------------------------------------------------------------
  logic w_boot_start;

  assign w_boot_start = (state_q == ST_LOAD) && (state_d == ST_BOOT);

  always_comb begin
    wr_seen_d = wr_seen_q;
    if (state_d != ST_LOAD) begin
      wr_seen_d = 1'b0;
    end else if (ioctl_wr) begin
      wr_seen_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (w_boot_start) begin
      cnt_d = CNT_W'(RST_CYCLES - 1);
    end else if ((state_q == ST_BOOT) && (cnt_q != '0)) begin
      // Saturates at zero; never wraps.
      cnt_d = cnt_q - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // E synchronizer and matching address/R-W delay pipe
  // --------------------------------------------------------------------------
  logic        e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
  logic [16:0] a1_q, a1_d, a2_q, a2_d;   // {R/W, A15-A0}
  logic        w_e_fall;

  always_comb begin
    e1_d = w_e;
    e2_d = e1_q;
    e3_d = e2_q;
    a1_d = a1_q;
    a2_d = a2_q;
    // Address pipe freezes outside RUN so stale bus activity cannot load a
    // bank while the machine is held in reset or unloaded.
    if (w_run) begin
      a1_d = {w_rw, w_addr};
      a2_d = a1_q;
    end
  end

  assign w_e_fall = e3_q & ~e2_q;

  // --------------------------------------------------------------------------
  // Bank register
  // --------------------------------------------------------------------------
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              w_bank_wr;

  // a2_q[16] is the delayed R/W, a2_q[15:8] the delayed high address byte.
  assign w_bank_wr = w_run && w_e_fall && !a2_q[16] && (a2_q[15:8] == 8'h10);

  always_comb begin
    bank_d = bank_q;
    if (w_boot_start) begin
      bank_d = '0;
    end else if (w_bank_wr) begin
      bank_d = a2_q[BANK_W-1:0];
    end
  end

  assign bank = bank_q;

  // --------------------------------------------------------------------------
  // Address decode (combinational, zero latency)
  // --------------------------------------------------------------------------
  logic w_win;
  logic w_bsel;
  logic w_sel;

  assign w_win  = (w_addr[15:13] == 3'b001);
  assign w_bsel = !w_rw && (w_addr[15:8] == 8'h10);
  assign w_sel  = w_run && (w_win || w_bsel);

  // --------------------------------------------------------------------------
  // Read-data qualifier
  // --------------------------------------------------------------------------
  logic rd_q, rd_d;

  assign rd_d = w_run && w_win && w_rw;

  // --------------------------------------------------------------------------
  // Sequential datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_seen_q <= 1'b0;
      cnt_q     <= '0;
      e1_q      <= 1'b0;
      e2_q      <= 1'b0;
      e3_q      <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      bank_q    <= '0;
      rd_q      <= 1'b0;
    end else begin
      wr_seen_q <= wr_seen_d;
      cnt_q     <= cnt_d;
      e1_q      <= e1_d;
      e2_q      <= e2_d;
      e3_q      <= e3_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      bank_q    <= bank_d;
      rd_q      <= rd_d;
    end
  end

  // --------------------------------------------------------------------------
  // ROM storage: written by the download port, read every cycle. Contents
  // survive reset, so this array carries no reset.
  // --------------------------------------------------------------------------
  logic [7:0]        rom_mem [0:ROM_DEPTH-1];
  logic [7:0]        rom_rdata_q;
  logic              w_rom_we;
  logic [ROM_AW-1:0] w_rom_waddr;
  logic [ROM_AW-1:0] w_rom_raddr;

  assign w_rom_we    = ioctl_wr && (ioctl_download || (state_q == ST_LOAD));
  assign w_rom_waddr = ioctl_addr[ROM_AW-1:0];
  assign w_rom_raddr = {bank_q, w_addr[12:0]};

  always_ff @(posedge clk_sys) begin
    if (w_rom_we) begin
      rom_mem[w_rom_waddr] <= ioctl_dout;
    end
    rom_rdata_q <= rom_mem[w_rom_raddr];
  end

  // --------------------------------------------------------------------------
  // Connector outputs. D must be zero when not driving: the machine ORs it
  // into its own data bus.
  // --------------------------------------------------------------------------
  logic [7:0] w_dout;

  assign w_dout = rd_q ? rom_rdata_q : 8'h00;
  assign exp_in = {w_dout, 1'b0, w_boot_rst, w_sel};

  // Address bits beyond the ROM and low delayed-address bits above the bank
  // field are intentionally unused.
  logic w_unused_bits;
  assign w_unused_bits = ^{ioctl_addr[23:ROM_AW], a2_q[7:BANK_W]};

endmodule
`default_nettype wire

// File: tb/tb_mc10_exp_cart.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc10_exp_cart
// Purpose  : Self-checking bench for mc10_exp_cart. Stimulus pushes expected
//            values into a queue; a monitor pops and compares them on the
//            falling clock edge.
// Revision : 1.1 - immediate reset-state and wait-expiry checks
// ============================================================================
module tb_mc10_exp_cart;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [17:0] exp_out;
    logic [10:0] exp_in;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [23:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        cart_loaded;
    logic [2:0]  bank;

    always #5 clk_sys = ~clk_sys;

    mc10_exp_cart #(.BANK_W(3), .RST_CYCLES(1024)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .exp_out        (exp_out),
        .exp_in         (exp_in),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .cart_loaded    (cart_loaded),
        .bank           (bank)
    );

    // kind: 0 sel, 1 D, 2 exp_in[1], 3 cart_loaded, 4 bank, 5 exp_in, 6 measured
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        logic [31:0] meas;
    } chk_t;

    chk_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] actual(input int kind, input logic [31:0] meas);
        case (kind)
            0:       return {31'd0, exp_in[0]};
            1:       return {24'd0, exp_in[10:3]};
            2:       return {31'd0, exp_in[1]};
            3:       return {31'd0, cart_loaded};
            4:       return {29'd0, bank};
            5:       return {21'd0, exp_in};
            default: return meas;
        endcase
    endfunction

    // Monitor: drains every pending expectation at each falling edge.
    initial begin
        forever begin
            @(negedge clk_sys);
            while (q.size() > 0) begin
                chk_t        c;
                logic [31:0] a;
                c = q.pop_front();
                a = actual(c.kind, c.meas);
                checks++;
                if (a !== c.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", c.name, a, c.exp, $time);
                end
            end
        end
    end

    task automatic check_now(input string n, input logic [31:0] got, input logic [31:0] e);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", n, got, e, $time);
        end
    endtask

    task automatic push(input string n, input int kind, input logic [31:0] e);
        chk_t c;
        c.name = n; c.kind = kind; c.exp = e; c.meas = '0;
        q.push_back(c);
    endtask

    task automatic push_meas(input string n, input logic [31:0] m, input logic [31:0] e);
        chk_t c;
        c.name = n; c.kind = 6; c.exp = e; c.meas = m;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_bus(input logic rw, input logic [15:0] a, input logic e);
        exp_out = {rw, a, e};
    endtask

    // Read cycle: sel checked immediately, D one clock later.
    task automatic cpu_read(input logic [15:0] a, input logic exp_sel,
                            input logic [7:0] exp_d, input string n);
        set_bus(1'b1, a, 1'b1);
        push({n, "_sel"}, 0, {31'd0, exp_sel});
        tick();
        push({n, "_d"}, 1, {24'd0, exp_d});
        tick();
        set_bus(1'b1, a, 1'b0);
        repeat (3) tick();
    endtask

    // Write cycle: bank must hold for two edges after E falls, update on third.
    task automatic cpu_write(input logic [15:0] a, input logic exp_sel,
                             input logic [2:0] b_before, input logic [2:0] b_after,
                             input string n);
        set_bus(1'b0, a, 1'b1);
        push({n, "_sel"}, 0, {31'd0, exp_sel});
        tick();
        tick();
        set_bus(1'b0, a, 1'b0);
        tick();
        tick();
        push({n, "_bank_hold"}, 4, {29'd0, b_before});
        tick();
        push({n, "_bank_new"}, 4, {29'd0, b_after});
        set_bus(1'b1, 16'h8000, 1'b0);
        tick();
    endtask

    // Image byte i = i[7:0] ^ i[15:13]; ends one edge after download falls.
    task automatic download(input int n);
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            logic [15:0] iv;
            iv = 16'(i);
            ioctl_wr   = 1'b1;
            ioctl_addr = 24'(i);
            ioctl_dout = iv[7:0] ^ {5'd0, iv[15:13]};
            if ((i % 16384) == 0) push("rst_during_load", 2, 32'd1);
            tick();
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
    endtask

    // Counts falling edges with exp_in[1] high; bounded so the run cannot hang.
    task automatic measure_pulse(input string n);
        int cnt;
        bit done;
        cnt  = 0;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk_sys);
            if (exp_in[1]) cnt++;
            else done = 1'b1;
        end
        check_now({n, "_wait_expired"}, {31'd0, done}, 32'd1);
        push_meas(n, 32'(cnt), 32'd1024);
        tick();
    endtask

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        set_bus(1'b1, 16'h8000, 1'b0);
        tick();
        check_now("reset_exp_in_now", {21'd0, exp_in}, 32'h000);
        check_now("reset_cart_now", {31'd0, cart_loaded}, 32'd0);
        check_now("reset_bank_now", {29'd0, bank}, 32'd0);
        push("reset_exp_in", 5, 32'h000);
        push("reset_cart", 3, 32'd0);
        push("reset_bank", 4, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Not loaded: no response, no bank change.
        cpu_write(16'h1005, 1'b0, 3'd0, 3'd0, "noload_wr");
        cpu_read(16'h2000, 1'b0, 8'h00, "noload_rd");

        // Empty download returns to IDLE without a boot pulse.
        ioctl_download = 1'b1;
        tick();
        push("empty_load_rst", 2, 32'd1);
        tick();
        ioctl_download = 1'b0;
        tick();
        push("empty_idle_rst", 2, 32'd0);
        tick();
        push("empty_idle_rst2", 2, 32'd0);
        push("empty_idle_cart", 3, 32'd0);
        tick();

        // Full 64 KiB image and boot pulse.
        download(65536);
        push("boot_cart", 3, 32'd1);
        measure_pulse("boot_pulse_len");
        push("run_cart", 3, 32'd1);
        push("run_rst", 2, 32'd0);
        tick();

        // Window reads and bank switching.
        cpu_read(16'h2005, 1'b1, 8'h05, "rd2005_b0");
        cpu_read(16'h4000, 1'b0, 8'h00, "rd4000");
        cpu_write(16'h1003, 1'b1, 3'd0, 3'd3, "wr1003");
        cpu_read(16'h2005, 1'b1, 8'h06, "rd2005_b3");
        cpu_write(16'h10FF, 1'b1, 3'd3, 3'd7, "wr10ff");
        cpu_read(16'h3FFF, 1'b1, 8'hF8, "rd3fff_b7");
        cpu_read(16'h1003, 1'b0, 8'h00, "rd1003");
        push("rd1003_bank", 4, 32'd7);
        cpu_write(16'h2000, 1'b1, 3'd7, 3'd7, "wr_window");
        cpu_read(16'h2000, 1'b1, 8'h07, "rd2000_b7");

        // Reload, interrupted mid-BOOT.
        download(16);
        push("reload_bank0", 4, 32'd0);
        push("reload_cart", 3, 32'd1);
        repeat (100) tick();
        ioctl_download = 1'b1;
        tick();
        push("midboot_cart", 3, 32'd0);
        push("midboot_rst", 2, 32'd1);
        download(16);
        measure_pulse("reboot_pulse_len");
        push("reboot_bank0", 4, 32'd0);
        push("reboot_cart", 3, 32'd1);
        tick();

        // Asynchronous reset mid-RUN with a bank selected.
        cpu_write(16'h1005, 1'b1, 3'd0, 3'd5, "wr1005");
        set_bus(1'b1, 16'h2000, 1'b1);
        reset_n = 1'b0;
        #1;
        check_now("runrst_exp_in_now", {21'd0, exp_in}, 32'h000);
        check_now("runrst_cart_now", {31'd0, cart_loaded}, 32'd0);
        check_now("runrst_bank_now", {29'd0, bank}, 32'd0);
        push("runrst_exp_in", 5, 32'h000);
        push("runrst_cart", 3, 32'd0);
        push("runrst_bank", 4, 32'd0);
        tick();
        reset_n = 1'b1;
        set_bus(1'b1, 16'h8000, 1'b0);
        tick();
        cpu_read(16'h2000, 1'b0, 8'h00, "postrst_rd");

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc10_exp_cart.md
# mc10_exp_cart

Bank-switched cartridge responder for the MC-10 expansion connector, built from the machine side's `exp_out` (R/W, A15-A0, E) and `exp_in` (D7-D0, nmi, reset, sel) bundles. It decodes the CPU address, asserts `sel` to override on-board decoding, returns ROM data on `D7-D0`, and latches a bank number from address-only writes. The ROM image is loaded through the MiSTer download port, and loading it auto-boots the machine by pulsing the expansion reset line.

## Interface
- `BANK_W`, default 3: bank-register width; ROM holds 2^BANK_W 8 KiB pages.
- `RST_CYCLES`, default 1024: length of the boot reset pulse, in `clk_sys` cycles.

- `clk_sys` in 1: single clock; frequency at least 4× E.
- `reset_n` in 1: asynchronous, active-low reset.
- `exp_out` in 18: [17] R/W (1 = read), [16:1] A15-A0, [0] E.
- `exp_in` out 11: [10:3] D7-D0, [2] nmi (tied 0), [1] reset (active-high), [0] sel (active-high).
- `ioctl_download` in 1: high while an image transfer is in progress.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in 24: byte address; bits [BANK_W+12:0] are used.
- `ioctl_dout` in 8: byte data.
- `cart_loaded` out 1: cartridge present and responding.
- `bank` out BANK_W: current bank register.

## Operation
- Storage: ROM is a 2^(BANK_W+13) × 8 synchronous RAM.
  - Write port: download port.
  - Read address: {bank, A12-A0}, applied every cycle.
- FSM states: IDLE, LOAD, BOOT, RUN.
  - IDLE→LOAD on `ioctl_download`=1, from any state.
  - LOAD→BOOT when `ioctl_download` falls and at least one `ioctl_wr` occurred. On this transition: bank←0, pulse counter←RST_CYCLES-1.
  - LOAD→IDLE when `ioctl_download` falls and no `ioctl_wr` occurred.
  - BOOT→RUN when the counter reaches 0.
- Outputs by state:
  - `cart_loaded`=1 in BOOT and RUN only.
  - `exp_in[1]`=1 in LOAD and BOOT, 0 otherwise.
- Decode is combinational from `exp_out`, and is active only in RUN:
  - win = (A15-A13 == 3'b001), i.e. $2000-$3FFF, either direction.
  - bsel = (R/W==0) && (A15-A8 == $10), i.e. $1000-$10FF.
  - sel = win | bsel.
  - Reads of $1000-$10FF do not assert sel.
- Read data:
  - rd_q ← (RUN && win && R/W) every cycle.
  - D7-D0 = rd_q ? rom_q : 8'h00.
  - D must be 0 whenever not driving, because the machine ORs it into its data bus.
- Bank writes:
  - E passes through a 2-FF synchronizer (e1, e2, plus e3 for edge detect).
  - A and R/W pass through a matching 2-stage delay pipe, so they stay aligned with e2.
  - E fall is detected when e3 & ~e2.
  - On that cycle, if RUN and delayed R/W==0 and delayed A15-A8==$10: bank ← delayed A[BANK_W-1:0].
  - Data bits are ignored; the bank number is carried in the address.
- Writes into the window are ignored, but sel is still asserted for them.

## Timing
- Reset (`reset_n` low), asynchronous:
  - State IDLE, `bank`=0, `cart_loaded`=0, `exp_in`=0, sync/pipe registers cleared.
  - ROM contents are kept.
- sel: combinational, zero-cycle latency from `exp_out`.
- Read data: D valid 1 `clk_sys` cycle after the address is stable.
- Bank change: `bank` updates 3 `clk_sys` cycles after E falls. The new page is seen on the next CPU access.
- Boot pulse:
  - `exp_in[1]` stays high for exactly RST_CYCLES cycles after leaving LOAD.
  - `cart_loaded` rises on the same edge on which `exp_in[1]` rises into BOOT.
- `ioctl_download` asserted mid-BOOT or mid-RUN:
  - Go immediately to LOAD.
  - sel, D and `cart_loaded` drop the next cycle.
- Simultaneous `ioctl_wr` and the `ioctl_download` fall: the byte is written and counts as a write.
- Counter wrap: the counter never wraps; it stops at 0.
- Address pipe and bank register are held in all states except RUN.

## Test plan
- Reset: assert `reset_n`=0 mid-RUN → same cycle `exp_in`=11'h000, `cart_loaded`=0, `bank`=0. A read of $2000 afterwards gives sel=0.
- Download and boot:
  - Stimulus: 64 KiB image, byte i = i[7:0] ^ i[15:13].
  - Required: `exp_in[1]` high throughout the download and for exactly 1024 cycles after, then 0; `cart_loaded`=1; state RUN.
- Read window: A=$2005, R/W=1, E high → sel=1 immediately; D=8'h05 one cycle later. Then A=$4000 → sel=0 and D=8'h00 one cycle later.
- Bank switch:
  - Write cycle at A=$1003 → `bank`=3 three cycles after E falls. Then read $2005 → D = 8'h05^3 = 8'h06.
  - Write at A=$10FF → `bank`=7.
  - Read at $1003 → sel=0 and `bank` unchanged.
- Not loaded: with no image, write $1005 and read $2000 → sel=0, D=0, `bank`=0. An empty download (no `ioctl_wr`) returns to IDLE with no reset pulse.
- Reload mid-operation: `ioctl_download` rises during BOOT → `cart_loaded`=0 next cycle and `exp_in[1]` stays high. After a new image completes, the pulse restarts with the full 1024 cycles and `bank`=0.
